// File: rtl/updown_counter_ctrl_if.sv
// Button/count bundle for the debounced up/down counter.
// The slave side is the counter itself; the master side raises the buttons
// and consumes the count, step pulses and debounced levels.
interface updown_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             btn_up;
  logic             btn_down;
  logic [WIDTH-1:0] count;
  logic             step_up;
  logic             step_down;
  logic             limit_hit;
  logic             up_held;
  logic             down_held;

  modport master (
    output btn_up, btn_down,
    input  count, step_up, step_down, limit_hit, up_held, down_held
  );

  modport slave (
    input  btn_up, btn_down,
    output count, step_up, step_down, limit_hit, up_held, down_held
  );
endinterface

// File: rtl/updown_counter_ctrl.sv
// Debounced up/down counter for two raw push-buttons.
// Each pin is synchronised, debounced and edge-detected; a held button
// auto-repeats after a delay. The count runs over 0..MODULUS-1 and either
// wraps or saturates at its limits, with one-cycle step/limit pulses.
module updown_counter_ctrl #(
  parameter int WIDTH          = 4,
  parameter int MODULUS        = 16,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000,
  parameter bit SATURATE       = 1'b0,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  updown_counter_ctrl_if.slave  bus
);

  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;
  localparam int DBW     = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW      = $clog2(RPT_MAX + 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

  localparam logic [DBW-1:0]   DB_LAST   = DBW'(DEBOUNCE_LIMIT - 1);
  localparam logic [TW-1:0]    DELAY_T   = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0]    RATE_T    = TW'(REPEAT_RATE);
  localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [1:0]       IDLE_PINS = ACTIVE_LOW ? 2'b11 : 2'b00;

  // Which interval the repeat timer is currently measuring.
  typedef enum logic {PH_FIRST, PH_RATE} rpt_phase_e;

  logic [1:0]       sync_meta;
  logic [1:0]       sync_lvl;
  logic [1:0]       pressed;
  logic [1:0]       held;
  logic [1:0]       other_held;
  logic [1:0]       press;
  logic [1:0]       rpt_fire;
  logic [1:0]       req;
  logic             both_req;
  logic [WIDTH-1:0] count_q;
  logic             step_up_q;
  logic             step_down_q;
  logic             limit_hit_q;

  // Two-flop synchroniser for both raw pins (bit 0 = up, bit 1 = down).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the synchroniser resets to the released pin level, so a button
      // held through reset is seen as a fresh press rather than a stale one.
      sync_meta <= IDLE_PINS;
      sync_lvl  <= IDLE_PINS;
    end else begin
      // NOTE: non-blocking assignments make the second flop take the old
      // value of the first, which is what gives two stages of settling.
      sync_meta <= {bus.btn_down, bus.btn_up};
      sync_lvl  <= sync_meta;
    end
  end

  assign pressed    = ACTIVE_LOW ? ~sync_lvl : sync_lvl;
  assign other_held = {held[BTN_UP], held[BTN_DN]};
  assign req        = press | rpt_fire;
  assign both_req   = &req;

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [DBW-1:0] db_cnt;
    logic           held_r;
    logic           held_d;
    logic           armed;
    rpt_phase_e     phase;
    logic [TW-1:0]  rpt_cnt;
    logic           rpt_due;

    // Debounce: accept a level change only after DEBOUNCE_LIMIT stable cycles.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt <= '0;
        held_r <= 1'b0;
        held_d <= 1'b0;
      end else begin
        held_d <= held_r;
        if (pressed[g] == held_r) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          held_r <= pressed[g];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end
    end

    assign held[g]     = held_r;
    assign press[g]    = held_r & ~held_d;
    assign rpt_due     = (phase == PH_RATE) ? (rpt_cnt == RATE_T) : (rpt_cnt == DELAY_T);
    assign rpt_fire[g] = REPEAT_EN && armed && held_r && !other_held[g] && rpt_due;

    // Repeat timer: counts cycles since the last step of a lone held button.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        armed   <= 1'b0;
        phase   <= PH_FIRST;
        rpt_cnt <= '0;
      end else if (!held_r || other_held[g] || both_req) begin
        armed   <= 1'b0;
        phase   <= PH_FIRST;
        rpt_cnt <= '0;
      end else if (press[g]) begin
        armed   <= REPEAT_EN;
        phase   <= PH_FIRST;
        rpt_cnt <= TW'(1);
      end else if (armed) begin
        if (rpt_fire[g]) begin
          phase   <= PH_RATE;
          rpt_cnt <= TW'(1);
        end else begin
          rpt_cnt <= rpt_cnt + TW'(1);
        end
      end
    end
  end

  // Count register and one-cycle status pulses; opposing requests cancel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      limit_hit_q <= 1'b0;
    end else begin
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      limit_hit_q <= 1'b0;
      if (req[BTN_UP] && !req[BTN_DN]) begin
        if (count_q == CNT_MAX) begin
          limit_hit_q <= 1'b1;
          if (!SATURATE) begin
            count_q   <= '0;
            step_up_q <= 1'b1;
          end
        end else begin
          count_q   <= count_q + WIDTH'(1);
          step_up_q <= 1'b1;
        end
      end else if (req[BTN_DN] && !req[BTN_UP]) begin
        if (count_q == '0) begin
          limit_hit_q <= 1'b1;
          if (!SATURATE) begin
            count_q     <= CNT_MAX;
            step_down_q <= 1'b1;
          end
        end else begin
          count_q     <= count_q - WIDTH'(1);
          step_down_q <= 1'b1;
        end
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.step_up   = step_up_q;
  assign bus.step_down = step_down_q;
  assign bus.limit_hit = limit_hit_q;
  assign bus.up_held   = held[BTN_UP];
  assign bus.down_held = held[BTN_DN];

endmodule
